sa_skew_feeder: RTL and testbench

- Sequential stage directly downstream of the img2col rearranger and upstream of the output-stationary systolic array.
- Latches one flattened feature-map matrix (FEATURE_MAP_NUM x K) and one transposed weight matrix (K x KERNEL_NUM), where K = WEIGHT_WIDTH*WEIGHT_HEIGHT.
- Streams both matrices into the array edges with diagonal skew: row a delayed a cycles, column f delayed f cycles.
- Adds accumulator-clear, drain and done sequencing.

---
 rtl/sa_skew_feeder_pkg.sv | 35 +++
 rtl/sa_skew_feeder_skew_lane.sv | 29 ++
 rtl/sa_skew_feeder.sv | 136 +++++++++++++
 tb/tb_sa_skew_feeder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_skew_feeder_pkg.sv
// Shared types and sizing helpers for the skewed systolic-array feeder.
// Element indexing is MSB-first: element 0 occupies the top bits of a packed vector.
package sa_skew_feeder_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFeed  = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   function automatic int unsigned calc_k(input int unsigned ww, input int unsigned wh);
      return ww * wh;
   endfunction

   function automatic int unsigned calc_f_len(input int unsigned k, input int unsigned fm,
                                              input int unsigned kn);
      return k + ((fm > kn) ? fm : kn) - 1;
   endfunction

   function automatic int unsigned calc_d_len(input int unsigned fm, input int unsigned kn);
      return (fm < kn) ? fm : kn;
   endfunction

   function automatic int unsigned calc_cnt_w(input int unsigned f_len);
      return ($clog2(f_len) < 1) ? 1 : $clog2(f_len);
   endfunction

   // Top bit of element idx inside a packed vector of total bits.
   function automatic int unsigned elem_msb(input int unsigned total, input int unsigned idx,
                                            input int unsigned bw);
      return total - 1 - idx * bw;
   endfunction

endpackage

// File: rtl/sa_skew_feeder_skew_lane.sv
// One array-edge lane: emits element (cnt - LANE_OFFSET) of its K-element vector while feeding.
module sa_skew_feeder_skew_lane #(
   parameter int          LANE_OFFSET = 0,
   parameter int unsigned K           = 9,
   parameter int unsigned BITWIDTH    = 8,
   parameter int unsigned CNT_W       = 5
) (
   input  logic [K*BITWIDTH-1:0] vec,
   input  logic [CNT_W-1:0]      cnt,
   input  logic                  feed_en,
   output logic [BITWIDTH-1:0]   data,
   output logic                  valid
);

   // b + LANE_OFFSET never exceeds F_LEN-1, so the truncating cast is exact.
   always_comb begin
      data  = '0;
      valid = 1'b0;
      if (feed_en) begin
         for (int b = 0; b < int'(K); b++) begin
            if (cnt == CNT_W'(b + LANE_OFFSET)) begin
               valid = 1'b1;
               data  = vec[(int'(K) - 1 - b) * int'(BITWIDTH) +: BITWIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/sa_skew_feeder.sv
// Latches one feature-map matrix and one weight matrix, then streams them diagonally skewed
// into the systolic array edges, followed by a drain phase and a one-cycle done pulse.
module sa_skew_feeder
   import sa_skew_feeder_pkg::*;
#(
   parameter int unsigned BITWIDTH        = 8,
   parameter int unsigned WEIGHT_WIDTH    = 3,
   parameter int unsigned WEIGHT_HEIGHT   = 3,
   parameter int unsigned FEATURE_MAP_NUM = 9,
   parameter int unsigned KERNEL_NUM      = 1
) (
   input  logic                                                     clk,
   input  logic                                                     rst,
   input  logic                                                     start,
   input  logic [FEATURE_MAP_NUM*WEIGHT_WIDTH*WEIGHT_HEIGHT*BITWIDTH-1:0] feature_maps_v,
   input  logic [WEIGHT_WIDTH*WEIGHT_HEIGHT*KERNEL_NUM*BITWIDTH-1:0] weights_v,
   output logic [FEATURE_MAP_NUM*BITWIDTH-1:0]                      row_data,
   output logic [FEATURE_MAP_NUM-1:0]                               row_valid,
   output logic [KERNEL_NUM*BITWIDTH-1:0]                           col_data,
   output logic [KERNEL_NUM-1:0]                                    col_valid,
   output logic                                                     acc_clr,
   output logic                                                     busy,
   output logic                                                     done
);

   localparam int unsigned K     = calc_k(WEIGHT_WIDTH, WEIGHT_HEIGHT);
   localparam int unsigned FM_W  = FEATURE_MAP_NUM * K * BITWIDTH;
   localparam int unsigned W_W   = K * KERNEL_NUM * BITWIDTH;
   localparam int unsigned F_LEN = calc_f_len(K, FEATURE_MAP_NUM, KERNEL_NUM);
   localparam int unsigned D_LEN = calc_d_len(FEATURE_MAP_NUM, KERNEL_NUM);
   localparam int unsigned CNT_W = calc_cnt_w(F_LEN);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FM_W-1:0]  fm_q;
   logic [W_W-1:0]   w_q;
   logic             latch;
   logic             feed_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         fm_q    <= '0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            fm_q <= feature_maps_v;
            w_q  <= weights_v;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               latch   = 1'b1;
               cnt_d   = '0;
               state_d = StFeed;
            end
         end
         StFeed: begin
            if (cnt_q == CNT_W'(F_LEN - 1)) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDrain: begin
            if (cnt_q == CNT_W'(D_LEN - 1)) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign feed_en = (state_q == StFeed);
   assign acc_clr = feed_en && (cnt_q == '0);
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);

   for (genvar a = 0; a < int'(FEATURE_MAP_NUM); a++) begin : g_row
      sa_skew_feeder_skew_lane #(
         .LANE_OFFSET(a),
         .K          (K),
         .BITWIDTH   (BITWIDTH),
         .CNT_W      (CNT_W)
      ) u_lane (
         .vec    (fm_q[elem_msb(FM_W, a * K, BITWIDTH) -: K * BITWIDTH]),
         .cnt    (cnt_q),
         .feed_en(feed_en),
         .data   (row_data[(FEATURE_MAP_NUM - a) * BITWIDTH - 1 -: BITWIDTH]),
         .valid  (row_valid[a])
      );
   end

   // Weight column f is strided in the packed vector; gather it into a contiguous lane vector.
   for (genvar f = 0; f < int'(KERNEL_NUM); f++) begin : g_col
      logic [K*BITWIDTH-1:0] col_vec;

      for (genvar e = 0; e < int'(K); e++) begin : g_elem
         assign col_vec[(K - e) * BITWIDTH - 1 -: BITWIDTH] =
            w_q[elem_msb(W_W, e * KERNEL_NUM + f, BITWIDTH) -: BITWIDTH];
      end

      sa_skew_feeder_skew_lane #(
         .LANE_OFFSET(f),
         .K          (K),
         .BITWIDTH   (BITWIDTH),
         .CNT_W      (CNT_W)
      ) u_lane (
         .vec    (col_vec),
         .cnt    (cnt_q),
         .feed_en(feed_en),
         .data   (col_data[(KERNEL_NUM - f) * BITWIDTH - 1 -: BITWIDTH]),
         .valid  (col_valid[f])
      );
   end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: a job-time model checked every cycle plus directed literal checks.
module tb_sa_skew_feeder;

   localparam int BW    = 8;
   localparam int FM    = 9;
   localparam int KN    = 1;
   localparam int K     = 9;
   localparam int F_LEN = K + ((FM > KN) ? FM : KN) - 1;
   localparam int D_LEN = (FM < KN) ? FM : KN;
   localparam int FMT   = FM * K * BW;
   localparam int WT    = K * KN * BW;

   logic             clk = 1'b0;
   logic             rst, start;
   logic [FMT-1:0]   fm_v;
   logic [WT-1:0]    w_v;
   logic [FM*BW-1:0] row_data;
   logic [FM-1:0]    row_valid;
   logic [KN*BW-1:0] col_data;
   logic [KN-1:0]    col_valid;
   logic             acc_clr, busy, done;

   sa_skew_feeder #(
      .BITWIDTH       (BW),
      .WEIGHT_WIDTH   (3),
      .WEIGHT_HEIGHT  (3),
      .FEATURE_MAP_NUM(FM),
      .KERNEL_NUM     (KN)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .feature_maps_v(fm_v),
      .weights_v     (w_v),
      .row_data      (row_data),
      .row_valid     (row_valid),
      .col_data      (col_data),
      .col_valid     (col_valid),
      .acc_clr       (acc_clr),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_busy  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] row_of(input int a);
      return row_data[(FM - a) * BW - 1 -: BW];
   endfunction

   function automatic logic [BW-1:0] col_of(input int f);
      return col_data[(KN - f) * BW - 1 -: BW];
   endfunction

   // Model: a job is "time since the latching edge"; outputs follow from t alone.
   logic [BW-1:0] mfm[FM][K];
   logic [BW-1:0] mw[K][KN];
   bit            m_act  = 1'b0;
   bit            m_init = 1'b0;
   int            m_t    = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_act  = 1'b0;
         m_t    = 0;
         m_init = 1'b1;
      end else if (m_act) begin
         if (m_t == F_LEN + D_LEN) m_act = 1'b0;
         else m_t++;
      end else if (start) begin
         m_act = 1'b1;
         m_t   = 0;
         for (int a = 0; a < FM; a++)
            for (int b = 0; b < K; b++)
               mfm[a][b] = fm_v[FMT - 1 - (a * K + b) * BW -: BW];
         for (int e = 0; e < K; e++)
            for (int f = 0; f < KN; f++)
               mw[e][f] = w_v[WT - 1 - (e * KN + f) * BW -: BW];
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         logic [FM*BW-1:0] e_rd;
         logic [FM-1:0]    e_rv;
         logic [KN*BW-1:0] e_cd;
         logic [KN-1:0]    e_cv;
         bit               feeding;
         e_rd    = '0;
         e_rv    = '0;
         e_cd    = '0;
         e_cv    = '0;
         feeding = m_act && (m_t < F_LEN);
         for (int a = 0; a < FM; a++) begin
            if (feeding && (m_t - a) >= 0 && (m_t - a) < K) begin
               e_rv[a] = 1'b1;
               e_rd[(FM - a) * BW - 1 -: BW] = mfm[a][m_t - a];
            end
         end
         for (int f = 0; f < KN; f++) begin
            if (feeding && (m_t - f) >= 0 && (m_t - f) < K) begin
               e_cv[f] = 1'b1;
               e_cd[(KN - f) * BW - 1 -: BW] = mw[m_t - f][f];
            end
         end
         check("row_data", row_data, e_rd);
         check("row_valid", row_valid, e_rv);
         check("col_data", col_data, e_cd);
         check("col_valid", col_valid, e_cv);
         check("acc_clr", acc_clr, m_act && m_t == 0);
         check("busy", busy, m_act);
         check("done", done, m_act && m_t == F_LEN + D_LEN);
      end
   end

   always @(negedge clk) begin
      if (done) n_done++;
      if (busy) n_busy++;
   end

   task automatic advance(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Pulse start across one edge; returns in the first FEED cycle (cnt 0).
   task automatic launch();
      n_done = 0;
      n_busy = 0;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      #1;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (busy && i < 100) begin
         advance(1);
         i++;
      end
      check("wait_idle_timeout", busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      fm_v  = '0;
      w_v   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset_busy", busy, 1'b0);
      check("reset_row_valid", row_valid, '0);
      check("reset_done", done, 1'b0);

      // Skew pattern: fm[a][b] = a*16+b, w[e][0] = 0xF0+e.
      for (int a = 0; a < FM; a++)
         for (int b = 0; b < K; b++)
            fm_v[FMT - 1 - (a * K + b) * BW -: BW] = BW'(a * 16 + b);
      for (int e = 0; e < K; e++)
         w_v[WT - 1 - e * BW -: BW] = BW'(8'hF0 + e);
      advance(1);
      launch();
      check("cnt0_acc_clr", acc_clr, 1'b1);
      check("cnt0_col", col_of(0), 8'hF0);
      check("cnt0_col_valid", col_valid, 1'b1);
      advance(2);
      check("cnt2_row3", row_of(3), 8'h00);
      check("cnt2_row3_valid", row_valid[3], 1'b0);
      check("cnt2_acc_clr", acc_clr, 1'b0);
      advance(1);
      check("cnt3_row3", row_of(3), 8'h30);
      check("cnt3_row3_valid", row_valid[3], 1'b1);
      advance(5);
      check("cnt8_col", col_of(0), 8'hF8);
      advance(1);
      check("cnt9_col", col_of(0), 8'h00);
      check("cnt9_col_valid", col_valid, 1'b0);
      advance(2);
      check("cnt11_row3", row_of(3), 8'h38);
      advance(1);
      check("cnt12_row3", row_of(3), 8'h00);
      check("cnt12_row3_valid", row_valid[3], 1'b0);
      advance(4);
      check("cnt16_row8", row_of(8), 8'h88);
      check("cnt16_row8_valid", row_valid[8], 1'b1);
      advance(1);
      check("drain_busy", busy, 1'b1);
      check("drain_row_valid", row_valid, '0);
      check("drain_done", done, 1'b0);
      advance(1);
      check("done_pulse", done, 1'b1);
      advance(1);
      check("after_done", done, 1'b0);
      check("after_busy", busy, 1'b0);
      check("job_done_count", n_done, 1);
      check("job_busy_cycles", n_busy, 19);

      // Bit-exact passthrough of sign-bit values.
      fm_v = '0;
      w_v  = '0;
      fm_v[FMT - 1 -: BW] = 8'h80;
      w_v[WT - 1 -: BW]   = 8'hFF;
      launch();
      check("signed_row0", row_of(0), 8'h80);
      check("signed_col0", col_of(0), 8'hFF);
      check("signed_row1", row_of(1), 8'h00);
      advance(1);
      check("signed_row0_cnt1", row_of(0), 8'h00);
      check("signed_col0_cnt1", col_of(0), 8'h00);
      wait_idle();

      // start while busy is ignored.
      launch();
      advance(5);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      #1;
      check("ignored_start_acc_clr", acc_clr, 1'b0);
      wait_idle();
      check("ignored_start_dones", n_done, 1);
      check("ignored_start_busy", n_busy, 19);

      // start held high: relaunch after exactly one IDLE cycle.
      n_done = 0;
      start  = 1'b1;
      @(posedge clk);
      #2;
      advance(18);
      check("held_done", done, 1'b1);
      advance(1);
      check("held_idle_busy", busy, 1'b0);
      advance(1);
      check("held_relaunch_busy", busy, 1'b1);
      check("held_relaunch_acc_clr", acc_clr, 1'b1);
      start = 1'b0;
      wait_idle();
      check("held_dones", n_done, 2);

      // Reset mid-job (with start asserted alongside) aborts without done.
      launch();
      advance(7);
      check("pre_reset_busy", busy, 1'b1);
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_row_data", row_data, '0);
      check("rst_col_valid", col_valid, '0);
      check("rst_acc_clr", acc_clr, 1'b0);
      advance(25);
      check("rst_no_done", n_done, 0);
      launch();
      wait_idle();
      check("post_rst_dones", n_done, 1);
      check("post_rst_busy", n_busy, 19);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
